// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold, hold-time limit and
// registered rotating priority pointer.
//
// state | meaning
// IDLE  | no grant active; arbitrate among req at the next edge
// GRANT | idx_q owns the resource; cnt_q counts cycles held so far
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  logic [15:0]      req_dbl;
  logic [7:0]       req_rot;
  logic [2:0]       enc;
  logic [2:0]       winner;

  // Rotating right by ptr puts requester ptr at bit 0, so lowest-set-bit
  // priority becomes ptr, ptr+1, ... with wrap.
  assign req_dbl = {req, req} >> ptr_q;
  assign req_rot = req_dbl[7:0];

  always_comb begin
    enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) enc = i[2:0];
    end
  end

  assign winner = enc + ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          state_d = GRANT;
          idx_d   = winner;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 3'd1;
          cnt_d     = '0;
          expired_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == GRANT);
    gnt_idx   = idx_q;
    gnt       = gnt_valid ? (8'd1 << idx_q) : 8'd0;
    expired   = expired_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: hand-computed grant sequences covering
// latency, pointer wrap, release kinds, no-preemption and async reset.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expect an active grant to agent a.
  task automatic expect_gnt(input string tag, input int a);
    logic [7:0] onehot;
    onehot = 8'd1 << a;
    check_eq({tag, ".gnt"}, {24'd0, gnt}, {24'd0, onehot});
    check_eq({tag, ".idx"}, {29'd0, gnt_idx}, a);
    check_eq({tag, ".valid"}, {31'd0, gnt_valid}, 32'd1);
  endtask

  task automatic expect_idle(input string tag, input logic exp_expired);
    check_eq({tag, ".gnt"}, {24'd0, gnt}, 32'd0);
    check_eq({tag, ".valid"}, {31'd0, gnt_valid}, 32'd0);
    check_eq({tag, ".expired"}, {31'd0, expired}, {31'd0, exp_expired});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'd0;
    @(negedge clk);
    expect_idle("reset", 1'b0);
    check_eq("reset.idx", {29'd0, gnt_idx}, 32'd0);
    rst_n = 1'b1;

    // Single request: 1-cycle latency, drop 1 cycle after req falls, ptr -> 4
    req = 8'h08;
    tick();
    expect_gnt("single.c1", 3);
    tick();
    expect_gnt("single.c2", 3);
    req = 8'h00;
    tick();
    expect_idle("single.drop", 1'b0);
    req = 8'h18;
    tick();
    expect_gnt("ptr4", 4);
    req = 8'h00;
    tick();
    expect_idle("ptr4.drop", 1'b0);

    // Wrap: agent 5 grant/release leaves ptr=6
    req = 8'h20;
    tick();
    expect_gnt("wrap.a5", 5);
    req = 8'h00;
    tick();
    req = 8'h41;
    tick();
    expect_gnt("wrap.a6", 6);
    req = 8'h01;
    tick();
    expect_idle("wrap.gap", 1'b0);
    tick();
    expect_gnt("wrap.a0", 0);
    req = 8'h00;
    tick();

    // Voluntary release (ptr=1 now)
    req = 8'h04;
    tick();
    expect_gnt("vol.c1", 2);
    tick();
    expect_gnt("vol.c2", 2);
    req = 8'h00;
    tick();
    expect_idle("vol.rel", 1'b0);

    // Forced release after exactly MAX_HOLD cycles
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_gnt($sformatf("force.c%0d", c + 1), 2);
      check_eq("force.noexp", {31'd0, expired}, 32'd0);
    end
    tick();
    expect_idle("force.rel", 1'b1);
    tick();
    expect_gnt("force.regrant", 2);
    check_eq("force.exp_pulse", {31'd0, expired}, 32'd0);
    req = 8'h00;
    tick();
    expect_idle("force.end", 1'b0);

    // No preemption (ptr=3)
    req = 8'h10;
    tick();
    expect_gnt("nopre.a4", 4);
    req = 8'h12;
    tick();
    expect_gnt("nopre.hold1", 4);
    tick();
    expect_gnt("nopre.hold2", 4);
    req = 8'h02;
    tick();
    expect_idle("nopre.gap", 1'b0);
    tick();
    expect_gnt("nopre.a1", 1);
    req = 8'h00;
    tick();

    // Async reset mid-grant with idx=5
    req = 8'h20;
    tick();
    expect_gnt("rst.a5", 5);
    req = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("rst.async", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full rotation from ptr=0 with all requesting
    for (int k = 0; k < 9; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        expect_gnt($sformatf("rr.k%0d.c%0d", k, c), k % 8);
        check_eq($sformatf("rr.k%0d.c%0d.exp", k, c), {31'd0, expired}, 32'd0);
        if (c < 3) tick();
      end
      tick();
      expect_idle($sformatf("rr.k%0d.gap", k), 1'b1);
    end

    req = 8'h00;
    tick();
    tick();
    expect_idle("final", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
